ysyx_24110006_hzu: RTL and testbench

YSYX_24110006_HZU -- requirements
Module: ysyx_24110006_hzu

---
 rtl/ysyx_24110006_hzu_pkg.sv | 16 +
 rtl/ysyx_24110006_hzu.sv | 140 ++++++++++++++
 tb/tb_ysyx_24110006_hzu.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24110006_hzu_pkg.sv
// Shared core package for the hazard unit: in-flight entry layout and default table depth.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ysyx_24110006_hzu_pkg;

   // Default number of in-flight table entries (power of two, 2..8).
   localparam int HZU_DEPTH_DEFAULT = 4;

   // One in-flight instruction: does it write a GPR, which one, and is it a load.
   typedef struct packed {
      logic       valid_wr;
      logic [4:0] rd;
      logic       load;
   } hzu_entry_t;

endpackage

// File: rtl/ysyx_24110006_hzu.sv
// Hazard unit: tracks in-flight writers in issue order and stalls IDU on RAW/serialisation hazards.
// Latency: hit/conflict/forward outputs are combinational (zero cycle); occupancy outputs are registered.
// Backpressure: o_conflict stalls IDU; issue is refused while full unless a retire frees a slot that cycle.
//
// Ports:
//   i_clock, i_reset_n                 clock, async active-low reset
//   i_rs1/i_rs2, i_rs*_used, i_serial  IDU instruction sources and serialisation request
//   i_issue, i_issue_rd/wen/load       IDU->EXU handshake and issuing instruction's destination
//   i_retire, i_flush, i_exu_out_valid WBU completion, redirect, EXU bypass bus valid
//   o_conflict, o_fwd_rs1/rs2          stall and bypass selects
//   o_full, o_empty, o_count           in-flight occupancy
// Optional feature: define CONFIG_HZU_BYPASS_EN to forward youngest non-load results from EXU.
module ysyx_24110006_hzu
   import ysyx_24110006_hzu_pkg::*;
#(
   parameter int DEPTH = HZU_DEPTH_DEFAULT
) (
   input  logic                       i_clock,
   input  logic                       i_reset_n,
   input  logic [4:0]                 i_rs1,
   input  logic [4:0]                 i_rs2,
   input  logic                       i_rs1_used,
   input  logic                       i_rs2_used,
   input  logic                       i_serial,
   input  logic                       i_issue,
   input  logic [4:0]                 i_issue_rd,
   input  logic                       i_issue_wen,
   input  logic                       i_issue_load,
   input  logic                       i_retire,
   input  logic                       i_flush,
   input  logic                       i_exu_out_valid,
   output logic                       o_conflict,
   output logic                       o_fwd_rs1,
   output logic                       o_fwd_rs2,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   hzu_entry_t          tbl [DEPTH];
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic [CW-1:0]       count;

   logic                full;
   logic                empty;
   logic                issue_ok;
   logic                retire_ok;

   logic [DEPTH-1:0]       vld_vec;
   logic [DEPTH-1:0][4:0]  rd_vec;
   logic [DEPTH-1:0]       ld_vec;

   logic                hit_rs1;
   logic                hit_rs2;

   // A source hits when it is read, is not x0, and matches any live writer.
   // Retired entries have valid_wr cleared, so scanning every slot is exact.
   function automatic logic src_hit(input logic [4:0]            src,
                                    input logic                  used,
                                    input logic [DEPTH-1:0]      vld,
                                    input logic [DEPTH-1:0][4:0] rds);
      src_hit = 1'b0;
      if (used && src != 5'd0) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && rds[i] == src) src_hit = 1'b1;
         end
      end
   endfunction

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign retire_ok = i_retire && !empty;
   // When full, a same-cycle retire frees the slot the issue will take.
   assign issue_ok  = i_issue && !i_flush && (!full || i_retire);

   always_comb begin
      vld_vec = '0;
      rd_vec  = '0;
      ld_vec  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         vld_vec[i] = tbl[i].valid_wr;
         rd_vec[i]  = tbl[i].rd;
         ld_vec[i]  = tbl[i].load;
      end
   end

   assign hit_rs1 = src_hit(i_rs1, i_rs1_used, vld_vec, rd_vec);
   assign hit_rs2 = src_hit(i_rs2, i_rs2_used, vld_vec, rd_vec);

`ifdef CONFIG_HZU_BYPASS_EN
   logic [PW-1:0] young_idx;
   logic          young_fwd_ok;
   // The youngest entry is by definition the newest, so if it matches a source
   // it is that source's newest producer and its EXU result is the right value.
   assign young_idx    = wr_ptr - PW'(1);
   assign young_fwd_ok = !empty && i_exu_out_valid && vld_vec[young_idx] && !ld_vec[young_idx];
   assign o_fwd_rs1    = young_fwd_ok && i_rs1_used && i_rs1 != 5'd0 && rd_vec[young_idx] == i_rs1;
   assign o_fwd_rs2    = young_fwd_ok && i_rs2_used && i_rs2 != 5'd0 && rd_vec[young_idx] == i_rs2;
`else
   logic unused_bypass;
   assign unused_bypass = ^{i_exu_out_valid, ld_vec};
   assign o_fwd_rs1     = 1'b0;
   assign o_fwd_rs2     = 1'b0;
`endif

   assign o_conflict = !i_flush &&
                       ((hit_rs1 && !o_fwd_rs1) || (hit_rs2 && !o_fwd_rs2) ||
                        (i_serial && !empty) || full);
   assign o_full  = full;
   assign o_empty = empty;
   assign o_count = count;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
      end else begin
         // Clear before write: on full issue+retire both pointers alias and the new entry must win.
         if (retire_ok) begin
            tbl[rd_ptr].valid_wr <= 1'b0;
            rd_ptr               <= rd_ptr + PW'(1);
         end
         if (issue_ok) begin
            tbl[wr_ptr].valid_wr <= i_issue_wen && (i_issue_rd != 5'd0);
            tbl[wr_ptr].rd       <= i_issue_rd;
            tbl[wr_ptr].load     <= i_issue_load;
            wr_ptr               <= wr_ptr + PW'(1);
         end
         if (issue_ok && !retire_ok)      count <= count + CW'(1);
         else if (!issue_ok && retire_ok) count <= count - CW'(1);
      end
   end

endmodule

// File: tb/tb_ysyx_24110006_hzu.sv
// Self-checking bench for the hazard unit: queue-based reference model feeds a scoreboard.
// Latency: expectations for each cycle are pushed when inputs are driven, popped mid-cycle.
// Backpressure: n/a.
module tb_ysyx_24110006_hzu;
   import ysyx_24110006_hzu_pkg::*;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          i_clock = 1'b0;
   logic          i_reset_n;
   logic [4:0]    i_rs1, i_rs2, i_issue_rd;
   logic          i_rs1_used, i_rs2_used, i_serial, i_issue, i_issue_wen, i_issue_load;
   logic          i_retire, i_flush, i_exu_out_valid;
   logic          o_conflict, o_fwd_rs1, o_fwd_rs2, o_full, o_empty;
   logic [CW-1:0] o_count;

   typedef struct {
      string         tag;
      logic          conflict;
      logic          fwd1;
      logic          fwd2;
      logic          full;
      logic          empty;
      logic [CW-1:0] count;
   } exp_t;

   hzu_entry_t mq[$];
   exp_t       sb_q[$];
   int         n_vec = 0;
   int         n_err = 0;

   ysyx_24110006_hzu #(.DEPTH(DEPTH)) dut (
      .i_clock(i_clock), .i_reset_n(i_reset_n),
      .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rs1_used(i_rs1_used), .i_rs2_used(i_rs2_used),
      .i_serial(i_serial), .i_issue(i_issue), .i_issue_rd(i_issue_rd),
      .i_issue_wen(i_issue_wen), .i_issue_load(i_issue_load), .i_retire(i_retire),
      .i_flush(i_flush), .i_exu_out_valid(i_exu_out_valid),
      .o_conflict(o_conflict), .o_fwd_rs1(o_fwd_rs1), .o_fwd_rs2(o_fwd_rs2),
      .o_full(o_full), .o_empty(o_empty), .o_count(o_count)
   );

   always #5 i_clock = ~i_clock;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic m_hit(input logic [4:0] src, input logic used);
      m_hit = 1'b0;
      if (used && src != 5'd0)
         foreach (mq[i]) if (mq[i].valid_wr && mq[i].rd == src) m_hit = 1'b1;
   endfunction

   function automatic logic m_fwd(input logic [4:0] src, input logic used);
      m_fwd = 1'b0;
`ifdef CONFIG_HZU_BYPASS_EN
      if (mq.size() > 0 && i_exu_out_valid && used && src != 5'd0)
         m_fwd = mq[$].valid_wr && mq[$].rd == src && !mq[$].load;
`else
      m_fwd = used && 1'b0;
`endif
   endfunction

   function automatic exp_t m_expect(input string tag);
      exp_t e;
      logic h1, h2;
      e.tag   = tag;
      h1      = m_hit(i_rs1, i_rs1_used);
      h2      = m_hit(i_rs2, i_rs2_used);
      e.fwd1  = m_fwd(i_rs1, i_rs1_used);
      e.fwd2  = m_fwd(i_rs2, i_rs2_used);
      e.full  = (mq.size() == DEPTH);
      e.empty = (mq.size() == 0);
      e.count = CW'(mq.size());
      e.conflict = !i_flush && ((h1 && !e.fwd1) || (h2 && !e.fwd2) ||
                                (i_serial && mq.size() != 0) || e.full);
      return e;
   endfunction

   task automatic m_update();
      hzu_entry_t ne;
      logic ret_ok, iss_ok;
      ret_ok = i_retire && mq.size() > 0;
      iss_ok = i_issue && !i_flush && (mq.size() < DEPTH || i_retire);
      if (ret_ok) void'(mq.pop_front());
      if (iss_ok) begin
         ne.valid_wr = i_issue_wen && i_issue_rd != 5'd0;
         ne.rd       = i_issue_rd;
         ne.load     = i_issue_load;
         mq.push_back(ne);
      end
   endtask

   task automatic idle();
      i_rs1 = '0; i_rs2 = '0; i_rs1_used = 0; i_rs2_used = 0; i_serial = 0;
      i_issue = 0; i_issue_rd = '0; i_issue_wen = 0; i_issue_load = 0;
      i_retire = 0; i_flush = 0; i_exu_out_valid = 0;
   endtask

   // Inputs are driven just after a negedge; sample 2ns later, then advance one clock.
   task automatic cycle(input string tag);
      exp_t e;
      if (!i_reset_n) mq.delete();
      sb_q.push_back(m_expect(tag));
      #2;
      e = sb_q.pop_front();
      chk_val({e.tag, ".conflict"}, 32'(o_conflict), 32'(e.conflict));
      chk_val({e.tag, ".fwd1"},     32'(o_fwd_rs1),  32'(e.fwd1));
      chk_val({e.tag, ".fwd2"},     32'(o_fwd_rs2),  32'(e.fwd2));
      chk_val({e.tag, ".full"},     32'(o_full),     32'(e.full));
      chk_val({e.tag, ".empty"},    32'(o_empty),    32'(e.empty));
      chk_val({e.tag, ".count"},    32'(o_count),    32'(e.count));
      @(posedge i_clock);
      if (i_reset_n) m_update();
      @(negedge i_clock);
   endtask

   task automatic issue(input logic [4:0] rd, input logic wen, input logic ld);
      i_issue = 1; i_issue_rd = rd; i_issue_wen = wen; i_issue_load = ld;
   endtask

   initial begin
      idle();
      i_reset_n = 1'b0;
      @(negedge i_clock);
      // Reset state, with a source that would otherwise be looked up.
      i_rs1 = 5; i_rs1_used = 1; i_serial = 1;
      cycle("rst");
      chk_val("rst.count_lit", 32'(o_count), 0);
      i_reset_n = 1'b1;
      idle();

      // RAW on rd=5: stall until the cycle after retire.
      issue(5, 1, 0); cycle("raw_issue"); idle();
      i_rs1 = 5; i_rs1_used = 1;
      cycle("raw_wait");
      i_retire = 1; cycle("raw_retire"); i_retire = 0;
      cycle("raw_clear");
      chk_val("raw.conflict_lit", 32'(o_conflict), 0);
      idle();

      // x0 destination never creates a hazard.
      issue(0, 1, 0); cycle("x0_issue"); idle();
      i_rs1 = 0; i_rs1_used = 1; cycle("x0_read");
      chk_val("x0.count_lit", 32'(o_count), 1);
      idle(); i_retire = 1; cycle("x0_retire"); idle();

      // Fill to full, refused issue when full, issue+retire when full.
      for (int k = 1; k <= DEPTH; k++) begin
         issue(5'(k), 1, 0); cycle($sformatf("fill%0d", k));
      end
      idle(); cycle("full_idle");
      chk_val("full.lit", 32'(o_full), 1);
      issue(9, 1, 0); cycle("full_refused");
      i_retire = 1; cycle("full_swap");
      idle(); i_rs2 = 9; i_rs2_used = 1; cycle("full_after_swap");
      chk_val("swap.count_lit", 32'(o_count), 4);
      idle(); i_retire = 1;
      for (int k = 0; k < DEPTH; k++) cycle($sformatf("drain%0d", k));
      cycle("retire_empty");
      idle();

      // Serialising instruction waits for an empty pipe.
      issue(1, 1, 0); cycle("ser_i0"); issue(2, 0, 0); cycle("ser_i1"); idle();
      i_serial = 1; cycle("ser_wait");
      i_retire = 1; cycle("ser_ret0"); cycle("ser_ret1"); i_retire = 0;
      cycle("ser_empty");
      idle();

      // Flush blocks allocation and masks conflict.
      issue(6, 1, 0); i_flush = 1; cycle("flush_issue"); idle();
      issue(6, 1, 0); cycle("flush_real"); idle();
      i_rs1 = 6; i_rs1_used = 1; i_flush = 1; cycle("flush_mask");
      i_flush = 0; cycle("flush_unmask");
      idle(); i_retire = 1; cycle("flush_drain"); idle();

      // Bypass candidates: youngest non-load, youngest load, older producer.
      issue(7, 1, 0); cycle("byp_i"); idle();
      i_rs2 = 7; i_rs2_used = 1; i_exu_out_valid = 1; cycle("byp_alu");
      i_exu_out_valid = 0; cycle("byp_noexu");
      idle(); i_retire = 1; cycle("byp_r0"); idle();
      issue(7, 1, 1); cycle("byp_li"); idle();
      i_rs2 = 7; i_rs2_used = 1; i_exu_out_valid = 1; cycle("byp_load");
      idle(); issue(3, 1, 0); i_retire = 1; cycle("byp_swap"); idle();
      i_rs1 = 3; i_rs1_used = 1; i_rs2 = 3; i_rs2_used = 1; i_exu_out_valid = 1;
      cycle("byp_both");
      idle(); issue(7, 1, 0); cycle("byp_old_i"); issue(4, 1, 0); cycle("byp_young_i"); idle();
      i_rs1 = 7; i_rs1_used = 1; i_exu_out_valid = 1; cycle("byp_older");
      idle();

      // Random traffic.
      for (int k = 0; k < 300; k++) begin
         i_rs1 = 5'($urandom_range(0, 7)); i_rs2 = 5'($urandom_range(0, 7));
         i_rs1_used = 1'($urandom); i_rs2_used = 1'($urandom);
         i_serial = ($urandom_range(0, 7) == 0);
         i_issue = 1'($urandom); i_issue_rd = 5'($urandom_range(0, 7));
         i_issue_wen = ($urandom_range(0, 3) != 0); i_issue_load = ($urandom_range(0, 3) == 0);
         i_retire = 1'($urandom); i_flush = ($urandom_range(0, 9) == 0);
         i_exu_out_valid = 1'($urandom);
         cycle($sformatf("rnd%0d", k));
      end

      // Reset mid-operation discards every entry.
      idle(); issue(8, 1, 0); cycle("pre_rst"); idle();
      i_reset_n = 1'b0; i_rs1 = 8; i_rs1_used = 1;
      cycle("mid_rst");
      i_reset_n = 1'b1; cycle("post_rst");
      chk_val("post_rst.empty_lit", 32'(o_empty), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
